fpu_sub_sequencer: RTL and testbench

Operand sequencer and result collector wrapped around the `fp_subtract` core. It accepts (a, b) operand pairs on a valid/ready input channel and buffers them in a small FIFO. It issues one operation at a time to the subtractor with a single-cycle `data_valid` pulse, samples `diff`/`error` after a fixed latency, and presents each result on a valid/ready output channel. It is the only agent that drives the subtractor's operand inputs.

---
 rtl/fpu_sub_sequencer.sv | 143 ++++++++++++++
 tb/tb_fpu_sub_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_sub_sequencer.sv
// Operand FIFO, single-issue sequencer and result holder around the fp_subtract core.
// One operation is in flight at a time; its result is held on a valid/ready channel.
module fpu_sub_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [31:0]                          in_a,
    input  logic [31:0]                          in_b,
    output logic [31:0]                          core_a,
    output logic [31:0]                          core_b,
    output logic                                 core_valid,
    input  logic [31:0]                          core_diff,
    input  logic                                 core_error,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [31:0]                          out_diff,
    output logic                                 out_error,
    output logic                                 busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      count,
    output logic [7:0]                           err_cnt
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [WW-1:0]  wcnt;
    logic [63:0]    mem [FIFO_DEPTH];
    logic           push;
    logic           pop;
    logic           capture;
    logic           wcnt_load;
    logic           wcnt_dec;

    // Admission depends on occupancy only, so a pop never frees a slot in its own cycle.
    assign in_ready = rst && (count < DEPTH_C);
    assign push     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (count != CW'(0)) state_next = ISSUE;
            ISSUE: state_next = WAIT;
            WAIT:  if (wcnt == WW'(0)) state_next = HOLD;
            HOLD: begin
                if (out_ready) begin
                    state_next = (count != CW'(0)) ? ISSUE : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop       = 1'b0;
        capture   = 1'b0;
        wcnt_load = 1'b0;
        wcnt_dec  = 1'b0;
        case (state)
            IDLE:  pop = (count != CW'(0));
            ISSUE: wcnt_load = 1'b1;
            WAIT: begin
                capture  = (wcnt == WW'(0));
                wcnt_dec = (wcnt != WW'(0));
            end
            HOLD:  pop = out_ready && (count != CW'(0));
            default: ;
        endcase
    end

    // Storage array carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            wcnt       <= '0;
            core_a     <= '0;
            core_b     <= '0;
            core_valid <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            out_diff   <= '0;
            out_error  <= 1'b0;
            err_cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                {core_a, core_b} <= mem[rd_ptr];
            end
            count <= count + CW'(push) - CW'(pop);
            if (wcnt_load) begin
                wcnt <= WW'(LATENCY - 1);
            end else if (wcnt_dec) begin
                wcnt <= wcnt - WW'(1);
            end
            if (capture) begin
                out_diff  <= core_diff;
                out_error <= core_error;
                if (core_error && (err_cnt != 8'hFF)) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
            core_valid <= (state_next == ISSUE);
            out_valid  <= (state_next == HOLD);
            busy       <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_fpu_sub_sequencer.sv
// Bench for fpu_sub_sequencer: a fixed-latency subtractor stand-in, a transaction-level
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_fpu_sub_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAT   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        core_valid;
    logic [31:0] core_diff;
    logic        core_error;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_diff;
    logic        out_error;
    logic        busy;
    logic [2:0]  count;
    logic [7:0]  err_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpu_sub_sequencer #(.FIFO_DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .core_a(core_a), .core_b(core_b),
        .core_valid(core_valid), .core_diff(core_diff), .core_error(core_error),
        .out_valid(out_valid), .out_ready(out_ready), .out_diff(out_diff),
        .out_error(out_error), .busy(busy), .count(count), .err_cnt(err_cnt)
    );

    // Subtraction reference: exact results for the directed operand pairs.
    function automatic logic [32:0] fsub(input logic [31:0] a, input logic [31:0] b);
        logic na, nb, ia, ib;
        na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        if (na || nb || (ia && ib && (a[31] == b[31]))) return {1'b1, 32'h7FFF_FFFF};
        case ({a, b})
            64'h40400000_3F800000: return {1'b0, 32'h4000_0000};
            64'h40A00000_40400000: return {1'b0, 32'h4000_0000};
            64'h3F800000_40000000: return {1'b0, 32'hBF80_0000};
            64'h40000000_3F800000: return {1'b0, 32'h3F80_0000};
            64'h41200000_40A00000: return {1'b0, 32'h40A0_0000};
            default:               return {1'b0, a ^ {b[15:0], b[31:16]}};
        endcase
    endfunction

    // Core stand-in: the true result is visible only LAT-1 cycles after the data_valid
    // edge; at any other time it shows a corrupted value with the error flag inverted.
    logic [31:0] lat_a = '0;
    logic [31:0] lat_b = '0;
    int unsigned age = 100;
    logic [32:0] core_res;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            age <= 100;
        end else if (core_valid) begin
            lat_a <= core_a;
            lat_b <= core_b;
            age   <= 0;
        end else if (age < 100) begin
            age <= age + 1;
        end
    end

    always_comb begin
        core_res = fsub(lat_a, lat_b);
        if (age != LAT - 1) begin
            core_res = {~core_res[32], core_res[31:0] ^ 32'h5A5A_5A5A ^ 32'(age)};
        end
    end
    assign core_diff  = core_res[31:0];
    assign core_error = core_res[32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of waiting pairs, one op with an age, and a held result.
    logic [63:0] mq[$];
    bit          m_active = 0;
    bit          m_hold   = 0;
    int          m_age    = 0;
    logic [31:0] m_a = '0, m_b = '0, m_diff = '0;
    logic        m_err = 1'b0;
    int          m_errcnt = 0;

    initial forever begin
        logic [32:0] r;
        bit          do_push;
        @(negedge clk);
        if (!rst) begin
            mq.delete();
            m_active = 0; m_hold = 0; m_age = 0;
            m_a = '0; m_b = '0; m_diff = '0; m_err = 1'b0; m_errcnt = 0;
        end
        chk("in_ready",   32'(in_ready),   32'(rst && (mq.size() < DEPTH)));
        chk("count",      32'(count),      32'(mq.size()));
        chk("core_valid", 32'(core_valid), 32'(m_active && (m_age == 0)));
        chk("core_a",     core_a,          m_a);
        chk("core_b",     core_b,          m_b);
        chk("busy",       32'(busy),       32'(m_active || m_hold));
        chk("out_valid",  32'(out_valid),  32'(m_hold));
        chk("out_diff",   out_diff,        m_diff);
        chk("out_error",  32'(out_error),  32'(m_err));
        chk("err_cnt",    32'(err_cnt),    32'(m_errcnt));
        if (rst) begin
            do_push = in_valid && (mq.size() < DEPTH);
            if (m_hold) begin
                if (out_ready) begin
                    m_hold = 0;
                    if (mq.size() > 0) begin
                        {m_a, m_b} = mq.pop_front(); m_active = 1; m_age = 0;
                    end
                end
            end else if (m_active) begin
                if (m_age == LAT) begin
                    r = fsub(m_a, m_b);
                    m_diff = r[31:0]; m_err = r[32];
                    m_active = 0; m_hold = 1;
                    if (m_err && m_errcnt < 255) m_errcnt++;
                end else begin
                    m_age++;
                end
            end else if (mq.size() > 0) begin
                {m_a, m_b} = mq.pop_front(); m_active = 1; m_age = 0;
            end
            if (do_push) mq.push_back({in_a, in_b});
        end
    end

    // Stimulus helpers; all start and end 1 time unit after a rising edge.
    task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
        bit rdy;
        int guard = 0;
        in_valid = 1'b1; in_a = a; in_b = b;
        do begin
            @(negedge clk); rdy = in_ready;
            @(posedge clk); #1;
            guard++;
        end while (!rdy && guard < 200);
        if (!rdy) begin
            n_tests++; n_fail++;
            $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles", guard);
        end
        in_valid = 1'b0;
    endtask

    task automatic get_result(output logic [31:0] d, output logic e, output int c);
        bit found = 0;
        int guard = 0;
        d = '0; e = 1'b0; c = 0;
        while (!found && guard < 100) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                d = out_diff; e = out_error; c = cyc; found = 1;
            end
            @(posedge clk); #1;
            guard++;
        end
        if (!found) begin
            n_tests++; n_fail++;
            $display("FAIL result_timeout: no result within %0d cycles", guard);
        end
    endtask

    task automatic drain(input int limit);
        bit done = 0;
        int guard = 0;
        while (!done && guard < limit) begin
            @(negedge clk);
            done = !busy && (count == 3'd0);
            @(posedge clk); #1;
            guard++;
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: busy=%0d count=%0d after %0d cycles", busy, count, guard);
        end
    endtask

    logic [31:0] bp_a [6] = '{32'h40400000, 32'h40A00000, 32'h3F800000,
                              32'h40000000, 32'h41200000, 32'h7FC00000};
    logic [31:0] bp_b [6] = '{32'h3F800000, 32'h40400000, 32'h40000000,
                              32'h3F800000, 32'h40A00000, 32'h3F800000};
    logic [31:0] bp_exp [6] = '{32'h40000000, 32'h40000000, 32'hBF800000,
                                32'h3F800000, 32'h40A00000, 32'h3F800000};

    initial begin
        logic [31:0] d;
        logic        e;
        int          c;
        int          cv_cyc, ov_cyc;
        logic [31:0] ov_diff;
        logic        ov_err;
        logic [31:0] res_d [6];
        int          res_c [6];
        bit          ov;
        int          guard;

        // Reset values
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Basic: 3.0 - 1.0, latency measured from the accepting edge
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 32'h40400000; in_b = 32'h3F800000;
        @(posedge clk); #1 in_valid = 1'b0;
        cv_cyc = 0; ov_cyc = 0; ov_diff = '0; ov_err = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (core_valid && cv_cyc == 0) cv_cyc = n;
            if (out_valid && ov_cyc == 0) begin
                ov_cyc = n; ov_diff = out_diff; ov_err = out_error;
            end
            if (n == 12) chk("basic_busy_end", 32'(busy), 32'd0);
        end
        @(posedge clk); #1;
        chk("basic_core_valid_cycle", 32'(cv_cyc), 32'd2);
        chk("basic_out_valid_cycle",  32'(ov_cyc), 32'd7);
        chk("basic_diff",  ov_diff, 32'h40000000);
        chk("basic_error", 32'(ov_err), 32'd0);

        // Invalid operations: inf-inf and NaN operand
        push_pair(32'h7F800000, 32'h7F800000);
        push_pair(32'h7FC00000, 32'h3F800000);
        get_result(d, e, c);
        chk("inv0_diff", d, 32'h7FFFFFFF);
        chk("inv0_error", 32'(e), 32'd1);
        get_result(d, e, c);
        chk("inv1_diff", d, 32'h7FFFFFFF);
        chk("inv1_error", 32'(e), 32'd1);
        drain(50);
        chk("inv_err_cnt", 32'(err_cnt), 32'd2);

        // Backpressure: six back-to-back offers, five fit
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_a = bp_a[k]; in_b = bp_b[k];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_count_full", 32'(count), 32'd4);
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        guard = 0;
        do begin
            @(negedge clk); ov = out_valid;
            @(posedge clk); #1;
            guard++;
        end while (!ov && guard < 50);

        // Full boundary: offer a push on the same cycle as the HOLD->ISSUE pop
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 32'h40000000; in_b = 32'h3F800000;
        @(negedge clk);
        chk("full_count_before", 32'(count), 32'd4);
        chk("full_in_ready_before", 32'(in_ready), 32'd0);
        res_d[0] = out_diff; res_c[0] = cyc;
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_count_after_pop", 32'(count), 32'd3);
        chk("full_in_ready_after_pop", 32'(in_ready), 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("full_count_after_push", 32'(count), 32'd4);
        @(posedge clk); #1;
        for (int k = 1; k < 6; k++) begin
            get_result(d, e, c);
            res_d[k] = d; res_c[k] = c;
        end
        for (int k = 0; k < 6; k++) chk($sformatf("bp_order%0d", k), res_d[k], bp_exp[k]);
        for (int k = 1; k < 6; k++) chk($sformatf("bp_spacing%0d", k), 32'(res_c[k] - res_c[k-1]), 32'd6);
        drain(50);
        chk("bp_err_cnt", 32'(err_cnt), 32'd2);

        // Reset during WAIT with two entries queued
        push_pair(32'h40A00000, 32'h40400000);
        push_pair(32'h3F800000, 32'h40000000);
        push_pair(32'h41200000, 32'h40A00000);
        chk("mid_count_before", 32'(count), 32'd2);
        chk("mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_in_ready",  32'(in_ready), 32'd0);
        chk("mid_core_a",    core_a, 32'd0);
        chk("mid_out_diff",  out_diff, 32'd0);
        chk("mid_busy",      32'(busy), 32'd0);
        chk("mid_count",     32'(count), 32'd0);
        chk("mid_err_cnt",   32'(err_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            chk("mid_no_stale_out_valid", 32'(out_valid), 32'd0);
        end
        chk("mid_count_after", 32'(count), 32'd0);
        @(posedge clk); #1;

        // Saturation: 260 NaN operations
        for (int i = 0; i < 260; i++) push_pair(32'h7FC00000 + 32'(i), 32'h3F800000);
        drain(200);
        chk("sat_err_cnt", 32'(err_cnt), 32'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
